dma_bus_arbiter: RTL

Cycle-stealing arbiter that shares the external address/data bus between the 6502 core and up to `NREQ` graphics DMA requesters. These are display-list fetch, playfield fetch and refresh. It raises `HALT` toward the clock generator and waits until the core is actually stalled on a read cycle. It then grants the bus to one requester for a bounded burst and returns the bus to the CPU. It runs entirely on the fast clock and treats `phi2` as a sampled level.

---
 rtl/dma_bus_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dma_bus_arbiter.sv
// Cycle-stealing arbiter: halts the 6502 on a read cycle, lends the bus to one DMA requester for a bounded burst.
// Define DMA_ARB_RR_EN for round-robin arbitration; default is fixed priority with index 0 highest.
module dma_bus_arbiter #(
   parameter int NREQ      = 3,
   parameter int MAX_BURST = 8
) (
   input  logic            fclk,
   input  logic            rstAll,
   input  logic            phi2,
   input  logic            nRW,
   input  logic [NREQ-1:0] dmaReq,
   input  logic [NREQ-1:0] dmaDone,
   output logic            HALT,
   output logic [NREQ-1:0] dmaGrant,
   output logic            busOwner
);
   typedef enum logic [1:0] {IDLE, HALT_WAIT, GRANT, RELEASE} state_t;

   localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

   state_t          state, stateNext;
   logic [3:0]      burst, burstNext, burstInc;
   logic            p2q, cycEnd;
   logic            haltNext, ownerNext;
   logic            winDone, winLost, expiry;
   logic [NREQ-1:0] grantNext, others;
   int              arbStart;

   // One-hot winner: first set bit found searching upward from start, wrapping modulo NREQ.
   function automatic logic [NREQ-1:0] pickWinner(input logic [NREQ-1:0] req, input int start);
      logic [NREQ-1:0] oh;
      oh = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         for (int j = 0; j < NREQ; j++) begin
            if (req[j] && (j == ((start + i) % NREQ))) begin
               oh    = '0;
               oh[j] = 1'b1;
            end
         end
      end
      return oh;
   endfunction

   assign cycEnd = p2q & ~phi2;

`ifdef DMA_ARB_RR_EN
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] rrPtr, rrPtrNext;

   function automatic logic [PW-1:0] ptrAfter(input logic [NREQ-1:0] oh);
      logic [PW-1:0] p;
      p = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) p = PW'((i + 1) % NREQ);
      end
      return p;
   endfunction

   assign arbStart = int'(rrPtr);

   // A fresh grant always differs from the current one, so this catches every grant event.
   always_comb begin
      rrPtrNext = rrPtr;
      if ((grantNext != '0) && (grantNext != dmaGrant)) rrPtrNext = ptrAfter(grantNext);
   end

   always_ff @(posedge fclk) begin
      if (rstAll) rrPtr <= '0;
      else        rrPtr <= rrPtrNext;
   end
`else
   assign arbStart = 0;
`endif

   always_comb begin
      stateNext = state;
      burstNext = burst;
      grantNext = dmaGrant;
      haltNext  = HALT;
      ownerNext = busOwner;
      burstInc  = (burst >= BURST_MAX) ? BURST_MAX : burst + 4'd1;
      winDone   = |(dmaDone & dmaGrant);
      winLost   = ~|(dmaReq & dmaGrant);
      expiry    = cycEnd && (burstInc >= BURST_MAX);
      others    = dmaReq & ~dmaGrant;
      case (state)
         IDLE: begin
            if (|dmaReq) begin
               stateNext = HALT_WAIT;
               haltNext  = 1'b1;
            end
         end
         HALT_WAIT: begin
            // Only a read cycle end proves the core is stalled; write cycles run through HALT.
            if (~|dmaReq) begin
               stateNext = IDLE;
               haltNext  = 1'b0;
            end else if (cycEnd && nRW) begin
               stateNext = GRANT;
               grantNext = pickWinner(dmaReq, arbStart);
               ownerNext = 1'b1;
               burstNext = '0;
            end
         end
         GRANT: begin
            if (cycEnd) burstNext = burstInc;
            if (expiry || ((winDone || winLost) && (others == '0))) begin
               stateNext = RELEASE;
               grantNext = '0;
               haltNext  = 1'b0;
               ownerNext = 1'b0;
               burstNext = '0;
            end else if (winDone || winLost) begin
               grantNext = pickWinner(others, arbStart);
               burstNext = '0;
            end
         end
         RELEASE: begin
            if (cycEnd) begin
               stateNext = (|dmaReq) ? HALT_WAIT : IDLE;
               haltNext  = |dmaReq;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge fclk) begin
      if (rstAll) begin
         state    <= IDLE;
         burst    <= '0;
         p2q      <= 1'b0;
         HALT     <= 1'b0;
         dmaGrant <= '0;
         busOwner <= 1'b0;
      end else begin
         state    <= stateNext;
         burst    <= burstNext;
         p2q      <= phi2;
         HALT     <= haltNext;
         dmaGrant <= grantNext;
         busOwner <= ownerNext;
      end
   end
endmodule
